// File: rtl/handshake_pkg.sv
// Shared defaults for the handshake FIFO slice: beat width, depth and almost-full level.
package handshake_pkg;

    localparam int HS_WIDTH    = 32;
    localparam int HS_DEPTH    = 4;
    localparam int HS_AF_LEVEL = 3;

endpackage

// File: rtl/handshake_fifo_if.sv
// Valid/ready bus between the upstream stage, the FIFO and the downstream slave.
interface handshake_fifo_if
    import handshake_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = HS_DEPTH
);

    logic                       valid_i;
    logic                       ready_o;
    logic [WIDTH-1:0]           data_i;
    logic                       valid_o;
    logic                       ready_i;
    logic [WIDTH-1:0]           data_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       almost_full;

    // Driver side: offers beats upstream and provides slave back-pressure.
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, count_o, almost_full
    );

    // FIFO side.
    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, count_o, almost_full
    );

endinterface

// File: rtl/handshake_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module handshake_fifo_mem
    import handshake_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = HS_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately left out of reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Valid/ready FIFO: pointers, occupancy and flags; ready_o never depends on ready_i.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int WIDTH    = HS_WIDTH,
    parameter int DEPTH    = HS_DEPTH,
    parameter int AF_LEVEL = HS_AF_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    handshake_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] rd_data;
    logic             ready;
    logic             valid;
    logic             push;
    logic             pop;

    // Flags come only from registered occupancy; rst masks ready so no beat lands during reset.
    assign ready = (count_q != FULL_CNT) && !rst;
    assign valid = (count_q != '0);
    assign push  = bus.valid_i && ready;
    assign pop   = valid && bus.ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    handshake_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.data_i),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign bus.ready_o     = ready;
    assign bus.valid_o     = valid;
    assign bus.data_o      = valid ? rd_data : '0;
    assign bus.count_o     = count_q;
    assign bus.almost_full = (count_q >= AF_CNT);

endmodule

// File: tb/tb_handshake_fifo.sv
// Bench for handshake_fifo: directed vector table, streaming sequence and randomized queue-model run.
module tb_handshake_fifo;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;

    logic clk = 1'b0;
    logic rst;

    handshake_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    handshake_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rs;
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_data;
        int          e_cnt;
        logic        e_af;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] q[$];
    int          checks = 0;
    int          errors = 0;
    logic        cur_rs, cur_v, cur_r;
    logic [31:0] cur_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input string nm, input logic rs, input logic v, input logic [31:0] d,
                       input logic r, input logic e_rdy, input logic e_vld,
                       input logic [31:0] e_data, input int e_cnt, input logic e_af);
        vec_t t;
        t.nm = nm; t.rs = rs; t.v = v; t.d = d; t.r = r;
        t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_data = e_data; t.e_cnt = e_cnt; t.e_af = e_af;
        tbl.push_back(t);
    endtask

    // Apply inputs just after a posedge and move to the negedge for sampling.
    task automatic drive(input logic rs, input logic v, input logic [31:0] d, input logic r);
        cur_rs = rs; cur_v = v; cur_d = d; cur_r = r;
        rst = rs;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
        @(negedge clk);
    endtask

    // Reference model: a plain queue updated by the handshake rules at the clock edge.
    task automatic advance();
        bit do_push, do_pop;
        do_push = cur_v && !cur_rs && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && cur_r;
        @(posedge clk);
        if (cur_rs) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(cur_d);
        end
        #1;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_ready"}, 32'(bus.ready_o), 32'(!cur_rs && (q.size() < DEPTH)));
        chk({nm, "_valid"}, 32'(bus.valid_o), 32'(q.size() > 0));
        chk({nm, "_data"},  bus.data_o, (q.size() > 0) ? q[0] : 32'h0);
        chk({nm, "_count"}, 32'(bus.count_o), 32'(q.size()));
        chk({nm, "_af"},    32'(bus.almost_full), 32'(q.size() >= AF_LEVEL));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        @(posedge clk);
        #1;
        q.delete();

        //      name     rs v  data          r  rdy vld data          cnt af
        add("rst_hold",  1, 1, 32'hDEAD_0000, 0, 0, 0, 32'h0,         0, 0);
        add("rst_hold",  1, 1, 32'hDEAD_0001, 0, 0, 0, 32'h0,         0, 0);
        add("rst_hold",  1, 1, 32'hDEAD_0002, 0, 0, 0, 32'h0,         0, 0);
        add("rst_rel",   0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 0);
        add("single_in", 0, 1, 32'hA5A5_0001, 1, 1, 0, 32'h0,         0, 0);
        add("single_out",0, 0, 32'h0,         1, 1, 1, 32'hA5A5_0001, 1, 0);
        add("single_emp",0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 0);
        add("fill",      0, 1, 32'h10,        0, 1, 0, 32'h0,         0, 0);
        add("fill",      0, 1, 32'h11,        0, 1, 1, 32'h10,        1, 0);
        add("fill",      0, 1, 32'h12,        0, 1, 1, 32'h10,        2, 0);
        add("fill",      0, 1, 32'h13,        0, 1, 1, 32'h10,        3, 1);
        add("full_hold", 0, 1, 32'h14,        0, 0, 1, 32'h10,        4, 1);
        add("full_hold", 0, 1, 32'h14,        0, 0, 1, 32'h10,        4, 1);
        add("drain",     0, 1, 32'h14,        1, 0, 1, 32'h10,        4, 1);
        add("drain",     0, 1, 32'h14,        1, 1, 1, 32'h11,        3, 1);
        add("drain",     0, 0, 32'h0,         1, 1, 1, 32'h12,        3, 1);
        add("drain",     0, 0, 32'h0,         1, 1, 1, 32'h13,        2, 0);
        add("drain",     0, 0, 32'h0,         1, 1, 1, 32'h14,        1, 0);
        add("drain_emp", 0, 0, 32'h0,         1, 1, 0, 32'h0,         0, 0);
        add("fill2",     0, 1, 32'h20,        0, 1, 0, 32'h0,         0, 0);
        add("fill2",     0, 1, 32'h21,        0, 1, 1, 32'h20,        1, 0);
        add("fill2",     0, 1, 32'h22,        0, 1, 1, 32'h20,        2, 0);
        add("fill2",     0, 1, 32'h23,        0, 1, 1, 32'h20,        3, 1);
        add("full_pop",  0, 1, 32'h24,        1, 0, 1, 32'h20,        4, 1);
        add("push_pop",  0, 1, 32'h24,        1, 1, 1, 32'h21,        3, 1);
        add("hold3",     0, 0, 32'h0,         0, 1, 1, 32'h22,        3, 1);
        add("mid_rst",   1, 0, 32'h0,         0, 0, 1, 32'h22,        3, 1);
        add("post_rst",  0, 1, 32'h77,        0, 1, 0, 32'h0,         0, 0);
        add("post_rst",  0, 0, 32'h0,         0, 1, 1, 32'h77,        1, 0);
        add("post_rst",  0, 0, 32'h0,         1, 1, 1, 32'h77,        1, 0);
        add("post_rst",  0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rs, tbl[i].v, tbl[i].d, tbl[i].r);
            chk({tbl[i].nm, "_ready"}, 32'(bus.ready_o), 32'(tbl[i].e_rdy));
            chk({tbl[i].nm, "_valid"}, 32'(bus.valid_o), 32'(tbl[i].e_vld));
            chk({tbl[i].nm, "_data"},  bus.data_o, tbl[i].e_data);
            chk({tbl[i].nm, "_count"}, 32'(bus.count_o), 32'(tbl[i].e_cnt));
            chk({tbl[i].nm, "_af"},    32'(bus.almost_full), 32'(tbl[i].e_af));
            advance();
        end

        // Streaming: 20 beats back to back, one-cycle latency, occupancy pinned at 1.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 32'(i), 1'b1);
            chk("stream_valid", 32'(bus.valid_o), (i == 0) ? 32'd0 : 32'd1);
            chk("stream_data",  bus.data_o, (i == 0) ? 32'd0 : 32'(i - 1));
            chk("stream_count", 32'(bus.count_o), (i == 0) ? 32'd0 : 32'd1);
            chk("stream_ready", 32'(bus.ready_o), 32'd1);
            advance();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_last", bus.data_o, 32'd19);
        chk("stream_last_cnt", 32'(bus.count_o), 32'd1);
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("stream_empty", 32'(bus.valid_o), 32'd0);
        advance();

        // Randomized traffic against the queue model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  $urandom, ($urandom_range(0, 2) != 0));
            chk_model("rand");
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
